// File: rtl/servo_pwm_gen.sv
// 50 Hz servo PWM generator: clamped, slew-limited pulse width applied only on
// period boundaries, with IDLE / RUN / REST run-state control.
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYC = 500000,
    parameter int unsigned MIN_CYC    = 25000,
    parameter int unsigned MAX_CYC    = 50000,
    parameter int unsigned REST_CYC   = 37500,
    parameter int unsigned STEP_CYC   = 250,
    parameter int unsigned CNT_W      = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      duty_in,
    input  logic             duty_valid,
    input  logic             active,
    input  logic             rest,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] cur_width,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REST
    } state_e;

    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] REST_W = CNT_W'(REST_CYC);
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP_CYC);
    localparam logic [31:0]      MIN32  = 32'(MIN_CYC);
    localparam logic [31:0]      MAX32  = 32'(MAX_CYC);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] eff_next;
    logic [CNT_W-1:0] clamped;
    state_e           state_q, state_d;
    state_e           pend_q, pend_d;
    logic             pwm_q, pwm_d;
    logic             pstart_q, pstart_d;
    logic             boundary;

    always_comb begin
        boundary = (count_q == LAST_W);
        count_d  = boundary ? '0 : count_q + CNT_W'(1);

        if (rest) begin
            pend_d = ST_REST;
        end else if (active) begin
            pend_d = ST_RUN;
        end else begin
            pend_d = pend_q;
        end
        state_d = boundary ? pend_q : state_q;

        // Clamp over all 32 bits so oversized requests saturate instead of wrapping.
        if (duty_in < MIN32) begin
            clamped = MIN_W;
        end else if (duty_in > MAX32) begin
            clamped = MAX_W;
        end else begin
            clamped = duty_in[CNT_W-1:0];
        end
        target_d = duty_valid ? clamped : target_q;

        // Slew uses the pre-edge target but the post-boundary state.
        eff_next = (state_d == ST_REST) ? REST_W : target_q;
        width_d  = width_q;
        if (boundary) begin
            if (eff_next > width_q) begin
                width_d = (eff_next - width_q <= STEP_W) ? eff_next : width_q + STEP_W;
            end else begin
                width_d = (width_q - eff_next <= STEP_W) ? eff_next : width_q - STEP_W;
            end
        end

        // Outputs are built from next-state values so they register in step with count.
        pwm_d    = (state_d != ST_IDLE) && (count_d < width_d);
        pstart_d = (count_d == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            state_q  <= ST_IDLE;
            pend_q   <= ST_IDLE;
            target_q <= REST_W;
            width_q  <= REST_W;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            state_q  <= state_d;
            pend_q   <= pend_d;
            target_q <= target_d;
            width_q  <= width_d;
            pwm_q    <= pwm_d;
            pstart_q <= pstart_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;
    assign cur_width    = width_q;
    assign busy         = width_q != ((state_q == ST_REST) ? REST_W : target_q);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen on a shortened period; per-period widths,
// busy and high-clock counts are queued as expectations and checked at each period start.
module tb_servo_pwm_gen;

    localparam int unsigned P     = 200;
    localparam int unsigned MINC  = 40;
    localparam int unsigned MAXC  = 100;
    localparam int unsigned RESTC = 70;
    localparam int unsigned STEPC = 8;
    localparam int unsigned W     = 10;

    logic         clock;
    logic         reset;
    logic [31:0]  duty_in;
    logic         duty_valid;
    logic         active;
    logic         rest;
    logic         pwm_out;
    logic         period_start;
    logic [W-1:0] cur_width;
    logic         busy;

    servo_pwm_gen #(
        .PERIOD_CYC(P),
        .MIN_CYC   (MINC),
        .MAX_CYC   (MAXC),
        .REST_CYC  (RESTC),
        .STEP_CYC  (STEPC),
        .CNT_W     (W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .active      (active),
        .rest        (rest),
        .pwm_out     (pwm_out),
        .period_start(period_start),
        .cur_width   (cur_width),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned width;
        int unsigned highs;
        logic        bsy;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_e;
    bit          have_exp;
    int unsigned highs_acc;
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned w, input int unsigned hi, input logic b);
        exp_t e;
        e.width = w;
        e.highs = hi;
        e.bsy   = b;
        sb.push_back(e);
    endtask

    // One clock: advance to the falling edge, then run the scoreboard monitor.
    task automatic tick();
        @(negedge clock);
        if (reset) begin
            have_exp  = 1'b0;
            highs_acc = 0;
        end else if (period_start) begin
            if (have_exp) chk("period_highs", 32'(highs_acc), 32'(cur_e.highs));
            highs_acc = pwm_out ? 1 : 0;
            if (sb.size() > 0) begin
                cur_e    = sb.pop_front();
                have_exp = 1'b1;
                chk("period_width", 32'(cur_width), 32'(cur_e.width));
                chk("period_busy", 32'(busy), 32'(cur_e.bsy));
            end else begin
                have_exp = 1'b0;
            end
        end else if (pwm_out) begin
            highs_acc++;
        end
    endtask

    task automatic wait_ps(output int unsigned hi);
        bit found;
        hi    = 0;
        found = 1'b0;
        for (int i = 0; i < int'(2 * P + 10) && !found; i++) begin
            tick();
            if (period_start) found = 1'b1;
            else if (pwm_out) hi++;
        end
        if (!found) begin
            n_vec++;
            n_err++;
            $error("FAIL wait_ps_timeout observed=none expected=period_start");
        end
    endtask

    task automatic next_period();
        int unsigned dummy;
        wait_ps(dummy);
    endtask

    task automatic strobe(input logic [31:0] v);
        duty_in    = v;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; have_exp = 0; highs_acc = 0;
        reset = 1'b1; duty_in = '0; duty_valid = 1'b0; active = 1'b0; rest = 1'b0;
        repeat (3) tick();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_pstart", 32'(period_start), 32'd0);
        chk("rst_width", 32'(cur_width), 32'(RESTC));
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Active pulse at count 10: no output until the wrap, then full REST-width pulses.
        repeat (10) tick();
        active = 1'b1;
        tick();
        active = 1'b0;
        push(RESTC, RESTC, 1'b0);
        push(RESTC, RESTC, 1'b0);
        wait_ps(h);
        chk("idle_no_pulse", 32'(h), 32'd0);
        next_period();

        // Slew up to MAX in STEP increments, final step smaller.
        push(78, 78, 1'b1);
        push(86, 86, 1'b1);
        push(94, 94, 1'b1);
        push(100, 100, 1'b0);
        strobe(32'd100);
        chk("busy_after_req", 32'(busy), 32'd1);
        repeat (4) next_period();

        // Clamp cases.
        push(100, 100, 1'b0);
        strobe(32'hFFFF_FFFF);
        chk("busy_sat_max", 32'(busy), 32'd0);
        next_period();
        push(92, 92, 1'b1);
        push(90, 90, 1'b0);
        strobe(32'd90);
        repeat (2) next_period();
        push(98, 98, 1'b1);
        push(100, 100, 1'b0);
        strobe(32'h0000_0450);
        repeat (2) next_period();
        push(92, 92, 1'b1);
        push(84, 84, 1'b1);
        push(76, 76, 1'b1);
        push(68, 68, 1'b1);
        push(60, 60, 1'b1);
        push(52, 52, 1'b1);
        push(44, 44, 1'b1);
        push(40, 40, 1'b0);
        strobe(32'd10);
        repeat (8) next_period();

        // Request in the boundary cycle: that boundary still slews toward the old target.
        push(40, 40, 1'b1);
        push(48, 48, 1'b1);
        repeat (P - 1) tick();
        duty_in    = 32'd100;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        chk("bnd_pstart", 32'(period_start), 32'd1);
        next_period();
        next_period();

        // Reset mid-pulse.
        repeat (50) tick();
        chk("pre_rst_pwm", 32'(pwm_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_pwm", 32'(pwm_out), 32'd0);
        chk("async_rst_width", 32'(cur_width), 32'(RESTC));
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_pstart", 32'(period_start), 32'd0);
        tick();
        reset = 1'b0;

        // rest and active together: REST wins and holds width at REST_CYC.
        repeat (5) tick();
        rest = 1'b1; active = 1'b1;
        tick();
        rest = 1'b0; active = 1'b0;
        push(RESTC, RESTC, 1'b0);
        wait_ps(h);
        chk("idle_no_pulse2", 32'(h), 32'd0);
        push(RESTC, RESTC, 1'b0);
        push(RESTC, RESTC, 1'b0);
        strobe(32'd90);
        chk("busy_in_rest", 32'(busy), 32'd0);
        repeat (2) next_period();
        push(78, 78, 1'b1);
        active = 1'b1;
        tick();
        active = 1'b0;
        repeat (2) next_period();

        // IDLE still slews the width but drives no pulse.
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        push(78, 0, 1'b1);
        push(86, 0, 1'b1);
        strobe(32'd100);
        wait_ps(h);
        chk("idle_no_pulse3", 32'(h), 32'd0);
        repeat (2) next_period();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
